apb_req_arbiter: RTL and testbench
==================================

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 16, PREADY-low cycles tolerated in ACCESS before abort; used only with APB_ARB_TIMEOUT_EN.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 PCLK  in  1  sole clock; all state updates on rising edge.
REQ-004 PRESET  in  1  synchronous active-high reset.
REQ-005 REQn_VALID  in  1  (n=0,1) request; held with its fields until REQn_DONE.
REQ-006 REQn_WRITE  in  1  1 = write, 0 = read.
REQ-007 REQn_ADDR  in  16  byte address.
REQ-008 REQn_WDATA  in  32  write data.
REQ-009 REQn_DONE  out  1  one-cycle completion pulse.
REQ-010 REQn_RDATA  out  32  read data; valid with DONE.
REQ-011 REQn_ERR  out  1  error flag; valid with DONE.
REQ-012 PADDR  out  16; PWRITE  out  1; PWDATA  out  32; PENABLE  out  1: shared APB master signals.
REQ-013 PSEL0..PSEL4  out  1 each: one-hot slave selects.
REQ-014 PREADY  in  1; PRDATA  in  32; PSLVERR  in  1: muxed slave response.

Function
REQ-015 FSM states: IDLE, SETUP, ACCESS, COMPLETE; all outputs registered.
REQ-016 IDLE: no VALID -> stay; else grant, latch ADDR/WRITE/WDATA/requester id, go SETUP.
REQ-017 Arbitration: round-robin; both VALID -> grant requester not granted last; last-grant pointer resets to 1 (first contest goes to 0).
REQ-018 Decode: slave index = ADDR[14:12]; 0..4 select PSEL0..4.
REQ-019 Index 5..7: no PSEL or PENABLE asserted; FSM IDLE->COMPLETE directly, ERR=1, RDATA=0.
REQ-020 SETUP: one PSELx=1, PENABLE=0, PADDR/PWRITE/PWDATA from latched request; next state ACCESS.
REQ-021 ACCESS: PSELx=1, PENABLE=1; PREADY=0 -> stay with all APB outputs stable.
REQ-022 ACCESS with PREADY=1 -> capture PSLVERR as ERR, PRDATA as RDATA (reads only; writes give RDATA=0), drop PSEL/PENABLE, go COMPLETE.
REQ-023 COMPLETE: DONE=1 for granted requester only, one cycle, RDATA/ERR driven; go IDLE.
REQ-024 RDATA/ERR hold until next DONE for that requester.
REQ-025 Zero-wait latency: VALID seen in IDLE cycle N -> SETUP N+1, ACCESS N+2, DONE N+3; decode error -> DONE N+1.
REQ-026 VALID deasserted mid-transfer is ignored; transfer completes and DONE still pulses.
REQ-027 VALID held after DONE is a new request, arbitrated in the following IDLE cycle.
REQ-028 Outside SETUP/ACCESS: PSEL0..4=0, PENABLE=0; PADDR/PWRITE/PWDATA hold last values.

Reset
REQ-029 PRESET=1 at an edge -> IDLE, PSEL0..4=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, DONE=0, RDATA=0, ERR=0, pointer=1, timeout counter=0.
REQ-030 Reset mid-transfer aborts it with no DONE; PSEL/PENABLE low the cycle after reset is sampled.

Configuration
REQ-031 Macro APB_ARB_TIMEOUT_EN defined: counter clears on SETUP->ACCESS and increments each ACCESS cycle with PREADY=0.
REQ-032 On reaching TIMEOUT_CYCLES: drop PSEL/PENABLE, go COMPLETE with ERR=1, RDATA=0; PREADY in that cycle is ignored.
REQ-033 Macro undefined: no counter; ACCESS waits for PREADY indefinitely.

Verification
REQ-034 REQ0 read 0x2004, PREADY=1, PRDATA=0xDEADBEEF -> PSEL2 high two cycles, PENABLE in the second; REQ0_DONE at N+3 with RDATA=0xDEADBEEF, ERR=0.
REQ-035 REQ0 and REQ1 writes, both VALID from reset -> REQ0 served first, then REQ1; PWDATA matches each; DONE pulses alternate.
REQ-036 REQ1 read 0x4010, PREADY low 3 ACCESS cycles, PSLVERR=1 -> APB outputs stable while waiting; REQ1_DONE at N+6, ERR=1.
REQ-037 REQ0 read 0x6000 -> no PSEL asserted; REQ0_DONE at N+1, ERR=1, RDATA=0.
REQ-038 APB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, PREADY held 0 -> abort after 4 ACCESS cycles, DONE with ERR=1; undefined -> no DONE after 100 cycles.
REQ-039 PRESET pulsed during ACCESS -> PSEL/PENABLE low next cycle, no DONE, next request starts cleanly at SETUP.

Source files
------------

// File: rtl/apb_req_arbiter_if.sv
// Signal bundle between the two-requester APB arbiter, its requesters and the muxed APB slave side.
// Handshake: a requester raises REQn_VALID with stable fields and holds them until REQn_DONE pulses.
// DONE is a one-cycle pulse, and RDATA/ERR are valid with it.
// APB follows SETUP (PSEL) then ACCESS (PSEL+PENABLE); the slave ends ACCESS with PREADY.
interface apb_req_arbiter_if;
  logic        REQ0_VALID;
  logic        REQ0_WRITE;
  logic [15:0] REQ0_ADDR;
  logic [31:0] REQ0_WDATA;
  logic        REQ0_DONE;
  logic [31:0] REQ0_RDATA;
  logic        REQ0_ERR;

  logic        REQ1_VALID;
  logic        REQ1_WRITE;
  logic [15:0] REQ1_ADDR;
  logic [31:0] REQ1_WDATA;
  logic        REQ1_DONE;
  logic [31:0] REQ1_RDATA;
  logic        REQ1_ERR;

  logic [15:0] PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic        PENABLE;
  logic        PSEL0;
  logic        PSEL1;
  logic        PSEL2;
  logic        PSEL3;
  logic        PSEL4;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;

  modport master (
    input  REQ0_VALID, REQ0_WRITE, REQ0_ADDR, REQ0_WDATA,
    output REQ0_DONE, REQ0_RDATA, REQ0_ERR,
    input  REQ1_VALID, REQ1_WRITE, REQ1_ADDR, REQ1_WDATA,
    output REQ1_DONE, REQ1_RDATA, REQ1_ERR,
    output PADDR, PWRITE, PWDATA, PENABLE,
    output PSEL0, PSEL1, PSEL2, PSEL3, PSEL4,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    output REQ0_VALID, REQ0_WRITE, REQ0_ADDR, REQ0_WDATA,
    input  REQ0_DONE, REQ0_RDATA, REQ0_ERR,
    output REQ1_VALID, REQ1_WRITE, REQ1_ADDR, REQ1_WDATA,
    input  REQ1_DONE, REQ1_RDATA, REQ1_ERR,
    input  PADDR, PWRITE, PWDATA, PENABLE,
    input  PSEL0, PSEL1, PSEL2, PSEL3, PSEL4,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that serves two requesters through one APB master onto five decoded slaves.
// Optional APB_ARB_TIMEOUT_EN aborts an ACCESS phase after TIMEOUT_CYCLES wait-state cycles.
module apb_req_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  apb_req_arbiter_if.master bus,
  output logic [1:0]        state_o
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_SETUP    = 2'd1;
  localparam logic [1:0] S_ACCESS   = 2'd2;
  localparam logic [1:0] S_COMPLETE = 2'd3;
  localparam logic [2:0] NUM_SLAVES = 3'd5;

  if (TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0]       state_q, state_d;
  logic             last_q, last_d;
  logic             id_q, id_d;
  logic [4:0]       psel_q, psel_d;
  logic             penable_q, penable_d;
  logic [15:0]      paddr_q, paddr_d;
  logic             pwrite_q, pwrite_d;
  logic [31:0]      pwdata_q, pwdata_d;
  logic [1:0]       done_q, done_d;
  logic [1:0][31:0] rdata_q, rdata_d;
  logic [1:0]       err_q, err_d;

  logic        any_valid;
  logic        gnt;
  logic        req_write;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_slave;

  // On a contest the requester that was not granted last wins.
  assign any_valid = bus.REQ0_VALID | bus.REQ1_VALID;
  assign gnt       = (bus.REQ0_VALID & bus.REQ1_VALID) ? ~last_q : bus.REQ1_VALID;
  assign req_write = gnt ? bus.REQ1_WRITE : bus.REQ0_WRITE;
  assign req_addr  = gnt ? bus.REQ1_ADDR  : bus.REQ0_ADDR;
  assign req_wdata = gnt ? bus.REQ1_WDATA : bus.REQ0_WDATA;
  assign req_slave = req_addr[14:12];

`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCW-1:0] tcnt_q, tcnt_d;
  logic           timeout_hit;
  assign timeout_hit = (tcnt_q == TCW'(TIMEOUT_CYCLES));
`endif

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    id_d      = id_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    done_d    = 2'b00;
    rdata_d   = rdata_q;
    err_d     = err_q;
`ifdef APB_ARB_TIMEOUT_EN
    tcnt_d    = tcnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          last_d = gnt;
          id_d   = gnt;
          if (req_slave < NUM_SLAVES) begin
            psel_d   = 5'b00001 << req_slave;
            paddr_d  = req_addr;
            pwrite_d = req_write;
            pwdata_d = req_wdata;
            state_d  = S_SETUP;
          end else begin
            // Unmapped slave: complete with an error without touching the bus.
            done_d[gnt]  = 1'b1;
            rdata_d[gnt] = '0;
            err_d[gnt]   = 1'b1;
            state_d      = S_COMPLETE;
          end
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        state_d   = S_ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
        tcnt_d    = '0;
`endif
      end
      S_ACCESS: begin
`ifdef APB_ARB_TIMEOUT_EN
        if (timeout_hit) begin
          psel_d        = '0;
          penable_d     = 1'b0;
          done_d[id_q]  = 1'b1;
          rdata_d[id_q] = '0;
          err_d[id_q]   = 1'b1;
          state_d       = S_COMPLETE;
        end else if (bus.PREADY) begin
`else
        if (bus.PREADY) begin
`endif
          psel_d        = '0;
          penable_d     = 1'b0;
          done_d[id_q]  = 1'b1;
          rdata_d[id_q] = pwrite_q ? 32'h0 : bus.PRDATA;
          err_d[id_q]   = bus.PSLVERR;
          state_d       = S_COMPLETE;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else begin
          tcnt_d = tcnt_q + 1'b1;
        end
`endif
      end
      S_COMPLETE: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;
      id_q      <= 1'b0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      done_q    <= '0;
      rdata_q   <= '0;
      err_q     <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      tcnt_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      id_q      <= id_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
`ifdef APB_ARB_TIMEOUT_EN
      tcnt_q    <= tcnt_d;
`endif
    end
  end

  assign bus.PSEL0      = psel_q[0];
  assign bus.PSEL1      = psel_q[1];
  assign bus.PSEL2      = psel_q[2];
  assign bus.PSEL3      = psel_q[3];
  assign bus.PSEL4      = psel_q[4];
  assign bus.PENABLE    = penable_q;
  assign bus.PADDR      = paddr_q;
  assign bus.PWRITE     = pwrite_q;
  assign bus.PWDATA     = pwdata_q;
  assign bus.REQ0_DONE  = done_q[0];
  assign bus.REQ0_RDATA = rdata_q[0];
  assign bus.REQ0_ERR   = err_q[0];
  assign bus.REQ1_DONE  = done_q[1];
  assign bus.REQ1_RDATA = rdata_q[1];
  assign bus.REQ1_ERR   = err_q[1];
  assign state_o        = state_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: a transaction-timeline model predicts every output on every cycle.
// Directed scenarios pin literal values, and a randomized phase exercises contention and wait states.
module tb_apb_req_arbiter;

  localparam int TO = 4;

  logic       pclk;
  logic       preset;
  logic [1:0] state;

  apb_req_arbiter_if bus ();

  apb_req_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .PCLK   (pclk),
    .PRESET (preset),
    .bus    (bus.master),
    .state_o(state)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model: one in-flight transaction described by its grant cycle and finish (DONE) cycle.
  bit          m_act = 0;
  int          m_g, m_f, m_stalls, m_slv;
  bit          m_id, m_bad, m_write;
  bit          m_last = 1;
  logic [15:0] m_addr;
  logic [31:0] m_wdata, m_resp_rdata;
  bit          m_resp_err;
  bit          m_just_done;
  bit          m_done_id;
  logic [15:0] h_paddr = '0;
  bit          h_pwrite = 0;
  logic [31:0] h_pwdata = '0;
  logic [31:0] h_rdata [2] = '{32'h0, 32'h0};
  bit          h_err [2] = '{1'b0, 1'b0};
  logic [4:0]  e_psel;
  bit          e_pen;
  bit          e_done [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [4:0] psel_vec();
    return {bus.PSEL4, bus.PSEL3, bus.PSEL2, bus.PSEL1, bus.PSEL0};
  endfunction

  task automatic model_expect();
    e_psel = '0; e_pen = 0; e_done[0] = 0; e_done[1] = 0; m_just_done = 0;
    if (m_act) begin
      if (!m_bad && cyc == m_g + 1) begin
        h_paddr = m_addr; h_pwrite = m_write; h_pwdata = m_wdata;
      end
      if (!m_bad && cyc >= m_g + 1 && (m_f < 0 || cyc < m_f)) begin
        e_psel[m_slv] = 1'b1;
        e_pen = (cyc >= m_g + 2);
      end
      if (cyc == m_f) begin
        e_done[m_id] = 1; h_rdata[m_id] = m_resp_rdata; h_err[m_id] = m_resp_err;
        m_act = 0; m_just_done = 1; m_done_id = m_id;
      end
    end
  endtask

  task automatic begin_cycle();
    @(negedge pclk);
    cyc++;
    model_expect();
    check("psel",    32'(psel_vec()),      32'(e_psel));
    check("penable", 32'(bus.PENABLE),     32'(e_pen));
    check("paddr",   32'(bus.PADDR),       32'(h_paddr));
    check("pwrite",  32'(bus.PWRITE),      32'(h_pwrite));
    check("pwdata",  bus.PWDATA,           h_pwdata);
    check("done0",   32'(bus.REQ0_DONE),   32'(e_done[0]));
    check("done1",   32'(bus.REQ1_DONE),   32'(e_done[1]));
    check("rdata0",  bus.REQ0_RDATA,       h_rdata[0]);
    check("rdata1",  bus.REQ1_RDATA,       h_rdata[1]);
    check("err0",    32'(bus.REQ0_ERR),    32'(h_err[0]));
    check("err1",    32'(bus.REQ1_ERR),    32'(h_err[1]));
  endtask

  task automatic end_cycle();
    bit v0, v1, id;
    v0 = bus.REQ0_VALID; v1 = bus.REQ1_VALID;
    if (preset) begin
      m_act = 0; m_last = 1; h_paddr = '0; h_pwrite = 0; h_pwdata = '0;
      h_rdata[0] = '0; h_rdata[1] = '0; h_err[0] = 0; h_err[1] = 0;
    end else if (m_act) begin
      if (!m_bad && cyc >= m_g + 2 && m_f < 0) begin
`ifdef APB_ARB_TIMEOUT_EN
        if (m_stalls == TO) begin
          m_f = cyc + 1; m_resp_err = 1; m_resp_rdata = '0;
        end else
`endif
        if (bus.PREADY) begin
          m_f = cyc + 1; m_resp_err = bus.PSLVERR;
          m_resp_rdata = m_write ? 32'h0 : bus.PRDATA;
        end else begin
          m_stalls++;
        end
      end
    end else if (!m_just_done && (v0 || v1)) begin
      id = (v0 && v1) ? !m_last : v1;
      m_last = id; m_act = 1; m_id = id; m_g = cyc; m_stalls = 0;
      m_addr  = id ? bus.REQ1_ADDR  : bus.REQ0_ADDR;
      m_write = id ? bus.REQ1_WRITE : bus.REQ0_WRITE;
      m_wdata = id ? bus.REQ1_WDATA : bus.REQ0_WDATA;
      m_slv   = int'(m_addr[14:12]);
      m_bad   = (m_slv >= 5);
      m_f     = m_bad ? cyc + 1 : -1;
      m_resp_err = 1; m_resp_rdata = '0;
    end
  endtask

  task automatic set_req(input int r, input logic v, input logic w, input logic [15:0] a,
                         input logic [31:0] d);
    if (r == 0) begin
      bus.REQ0_VALID = v; bus.REQ0_WRITE = w; bus.REQ0_ADDR = a; bus.REQ0_WDATA = d;
    end else begin
      bus.REQ1_VALID = v; bus.REQ1_WRITE = w; bus.REQ1_ADDR = a; bus.REQ1_WDATA = d;
    end
  endtask

  task automatic set_valid(input int r, input logic v);
    if (r == 0) bus.REQ0_VALID = v;
    else        bus.REQ1_VALID = v;
  endtask

  function automatic logic get_valid(input int r);
    return (r == 0) ? bus.REQ0_VALID : bus.REQ1_VALID;
  endfunction

  task automatic new_req(input int r);
    int unsigned idx;
    logic [15:0] a;
    idx = $urandom_range(0, 9);
    if (idx > 7) idx = $urandom_range(0, 4);
    a = {1'($urandom_range(0, 1)), 3'(idx), 12'($urandom)};
    set_req(r, 1'b1, 1'($urandom_range(0, 1)), a, $urandom);
  endtask

  task automatic auto_drive(input bit allow_new);
    for (int r = 0; r < 2; r++) begin
      if (m_just_done && int'(m_done_id) == r) begin
        if (allow_new && $urandom_range(0, 1) == 1) new_req(r);
        else set_valid(r, 1'b0);
      end else if (m_act && int'(m_id) == r) begin
        if (get_valid(r) && $urandom_range(0, 9) == 0) set_valid(r, 1'b0);
      end else if (!get_valid(r) && allow_new && $urandom_range(0, 2) == 0) begin
        new_req(r);
      end
    end
    bus.PREADY  = allow_new ? ($urandom_range(0, 3) != 0) : 1'b1;
    bus.PRDATA  = $urandom;
    bus.PSLVERR = ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int done_cnt;
    bit idle_ok;
    preset = 1'b1;
    set_req(0, 0, 0, 16'h0, 32'h0);
    set_req(1, 0, 0, 16'h0, 32'h0);
    bus.PREADY = 0; bus.PRDATA = '0; bus.PSLVERR = 0;

    begin_cycle(); end_cycle();
    begin_cycle(); preset = 1'b0; end_cycle();

    // Read from slave 2 with zero wait states.
    begin_cycle();
    set_req(0, 1, 0, 16'h2004, 32'h0);
    bus.PREADY = 1; bus.PRDATA = 32'hDEADBEEF; bus.PSLVERR = 0;
    end_cycle();
    begin_cycle();
    check("lit_setup_psel", 32'(psel_vec()), 32'h04);
    check("lit_setup_pen", 32'(bus.PENABLE), 32'h0);
    check("lit_setup_paddr", 32'(bus.PADDR), 32'h2004);
    end_cycle();
    begin_cycle();
    check("lit_access_psel", 32'(psel_vec()), 32'h04);
    check("lit_access_pen", 32'(bus.PENABLE), 32'h1);
    end_cycle();
    begin_cycle();
    check("lit_rd_done0", 32'(bus.REQ0_DONE), 32'h1);
    check("lit_rd_rdata0", bus.REQ0_RDATA, 32'hDEADBEEF);
    check("lit_rd_err0", 32'(bus.REQ0_ERR), 32'h0);
    set_valid(0, 0);
    end_cycle();

    // Unmapped slave index 6 completes next cycle with an error.
    begin_cycle(); set_req(0, 1, 0, 16'h6000, 32'h0); end_cycle();
    begin_cycle();
    check("lit_dec_done0", 32'(bus.REQ0_DONE), 32'h1);
    check("lit_dec_err0", 32'(bus.REQ0_ERR), 32'h1);
    check("lit_dec_rdata0", bus.REQ0_RDATA, 32'h0);
    check("lit_dec_psel", 32'(psel_vec()), 32'h0);
    set_valid(0, 0);
    end_cycle();

    // Contest right after reset: requester 0 first, then requester 1.
    begin_cycle(); preset = 1'b1;
    set_req(0, 1, 1, 16'h1000, 32'h11112222);
    set_req(1, 1, 1, 16'h3000, 32'h33334444);
    end_cycle();
    begin_cycle(); preset = 1'b0; end_cycle();
    begin_cycle();
    check("lit_rr_pwdata0", bus.PWDATA, 32'h11112222);
    check("lit_rr_psel0", 32'(psel_vec()), 32'h02);
    end_cycle();
    begin_cycle(); end_cycle();
    begin_cycle();
    check("lit_rr_done0", 32'(bus.REQ0_DONE), 32'h1);
    check("lit_rr_done1_lo", 32'(bus.REQ1_DONE), 32'h0);
    set_valid(0, 0);
    end_cycle();
    begin_cycle(); end_cycle();
    begin_cycle();
    check("lit_rr_pwdata1", bus.PWDATA, 32'h33334444);
    check("lit_rr_psel1", 32'(psel_vec()), 32'h08);
    end_cycle();
    begin_cycle(); end_cycle();
    begin_cycle();
    check("lit_rr_done1", 32'(bus.REQ1_DONE), 32'h1);
    check("lit_rr_done0_lo", 32'(bus.REQ0_DONE), 32'h0);
    set_valid(1, 0);
    end_cycle();

    // Read from slave 4 with three wait states and a slave error.
    begin_cycle(); set_req(1, 1, 0, 16'h4010, 32'h0); bus.PREADY = 0; bus.PSLVERR = 1; end_cycle();
    begin_cycle(); end_cycle();
    for (int i = 0; i < 3; i++) begin
      begin_cycle();
      check("lit_wait_psel", 32'(psel_vec()), 32'h10);
      check("lit_wait_pen", 32'(bus.PENABLE), 32'h1);
      check("lit_wait_paddr", 32'(bus.PADDR), 32'h4010);
      end_cycle();
    end
    begin_cycle(); bus.PREADY = 1; bus.PRDATA = 32'h12345678; end_cycle();
    begin_cycle();
    check("lit_wait_done1", 32'(bus.REQ1_DONE), 32'h1);
    check("lit_wait_err1", 32'(bus.REQ1_ERR), 32'h1);
    check("lit_wait_rdata1", bus.REQ1_RDATA, 32'h12345678);
    set_valid(1, 0);
    end_cycle();

    // Randomized contention, wait states, decode errors and mid-transfer VALID drops.
    for (int i = 0; i < 3000; i++) begin
      begin_cycle(); auto_drive(1'b1); end_cycle();
    end
    idle_ok = 0;
    for (int i = 0; i < 60 && !idle_ok; i++) begin
      begin_cycle(); auto_drive(1'b0); end_cycle();
      idle_ok = !m_act && !bus.REQ0_VALID && !bus.REQ1_VALID;
    end
    check("drain_idle", 32'(idle_ok), 32'h1);

    // Slave that never answers, then reset during the stuck transfer.
    begin_cycle(); set_req(0, 1, 0, 16'h1000, 32'h0); bus.PREADY = 0; end_cycle();
    done_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      begin_cycle();
      if (bus.REQ0_DONE) done_cnt++;
      if (m_just_done && m_done_id == 1'b0) set_valid(0, 0);
      bus.PREADY = 0;
      end_cycle();
    end
`ifdef APB_ARB_TIMEOUT_EN
    check("lit_hang_done_cnt", 32'(done_cnt), 32'h1);
    check("lit_hang_psel", 32'(psel_vec()), 32'h0);
`else
    check("lit_hang_done_cnt", 32'(done_cnt), 32'h0);
    check("lit_hang_psel", 32'(psel_vec()), 32'h02);
    check("lit_hang_pen", 32'(bus.PENABLE), 32'h1);
`endif
    begin_cycle(); preset = 1'b1; end_cycle();
    begin_cycle();
    check("lit_rst_psel", 32'(psel_vec()), 32'h0);
    check("lit_rst_pen", 32'(bus.PENABLE), 32'h0);
    check("lit_rst_done0", 32'(bus.REQ0_DONE), 32'h0);
    preset = 1'b0;
    set_req(0, 1, 1, 16'h3008, 32'hA5A5A5A5);
    bus.PREADY = 1;
    end_cycle();
    begin_cycle();
    check("lit_post_psel", 32'(psel_vec()), 32'h08);
    check("lit_post_pen", 32'(bus.PENABLE), 32'h0);
    check("lit_post_paddr", 32'(bus.PADDR), 32'h3008);
    end_cycle();
    begin_cycle(); end_cycle();
    begin_cycle();
    check("lit_post_done0", 32'(bus.REQ0_DONE), 32'h1);
    set_valid(0, 0);
    end_cycle();
    begin_cycle(); end_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
